// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline control: forwarding selects,
// per-stage instruction metadata and the register-match helper.
package riscv_pipe_pkg;

  // Metadata register fields are sized for the widest supported index; narrower
  // REG_ADDR_W values are zero-extended on entry.
  localparam int MAX_REG_W = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic [MAX_REG_W-1:0] rs1;
    logic [MAX_REG_W-1:0] rs2;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 reg_write;
    logic                 mem_read;
  } stage_meta_t;

  function automatic logic reg_match(input logic [MAX_REG_W-1:0] r,
                                     input logic [MAX_REG_W-1:0] s,
                                     input logic                 zero_reg);
    return (r == s) && !(zero_reg && (s == '0));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source: MEM result wins over WB result.
module fwd_sel
  import riscv_pipe_pkg::*;
#(
  parameter int FWD_EN   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [MAX_REG_W-1:0] src,
  input  logic                 src_used,
  input  logic                 mem_valid,
  input  logic                 mem_reg_write,
  input  logic [MAX_REG_W-1:0] mem_rd,
  input  logic                 wb_valid,
  input  logic                 wb_reg_write,
  input  logic [MAX_REG_W-1:0] wb_rd,
  output logic [1:0]           sel
);

  always_comb begin
    sel = FWD_RF;
    if (FWD_EN != 0 && src_used) begin
      if (mem_valid && mem_reg_write && reg_match(mem_rd, src, ZERO_REG != 0))
        sel = FWD_MEM;
      else if (wb_valid && wb_reg_write && reg_match(wb_rd, src, ZERO_REG != 0))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, flush and forwarding control for the 5-stage pipeline, with
// saturating stall/flush event counters.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_EN     = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ext_stall,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  pc_redirect,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  stage_meta_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_m;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic ex_hit, mem_hit, hazard_ex, hazard_mem, stall, redir;
  logic unused_meta;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    id_m           = '0;
    id_m.valid     = id_valid;
    id_m.rd        = MAX_REG_W'(id_rd);
    id_m.rs1       = MAX_REG_W'(id_rs1);
    id_m.rs2       = MAX_REG_W'(id_rs2);
    id_m.rs1_used  = id_rs1_used;
    id_m.rs2_used  = id_rs2_used;
    id_m.reg_write = id_reg_write;
    id_m.mem_read  = id_mem_read;
  end

  // WB is never a hazard source: the regfile writes before it is read.
  assign ex_hit  = (id_rs1_used && reg_match(ex_q.rd, id_m.rs1, ZERO_REG != 0)) ||
                   (id_rs2_used && reg_match(ex_q.rd, id_m.rs2, ZERO_REG != 0));
  assign mem_hit = (id_rs1_used && reg_match(mem_q.rd, id_m.rs1, ZERO_REG != 0)) ||
                   (id_rs2_used && reg_match(mem_q.rd, id_m.rs2, ZERO_REG != 0));
  assign hazard_ex  = ex_q.valid && ex_q.reg_write && ex_hit &&
                      (ex_q.mem_read || FWD_EN == 0);
  assign hazard_mem = (FWD_EN == 0) && mem_q.valid && mem_q.reg_write && mem_hit;
  assign stall = id_valid && (hazard_ex || hazard_mem);
  assign redir = ex_q.valid && ex_branch_taken;

  // Reset is folded in so enables stay low while it is held.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_redirect = 1'b0;
    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!reset && !ext_stall) begin
      mem_d = ex_q;
      wb_d  = mem_q;
      if (redir) begin
        pc_redirect = 1'b1;
        pc_en       = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        ex_d        = '0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (stall) begin
        idex_flush  = 1'b1;
        ex_d        = '0;
        stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
        ex_d    = id_m;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel #(.FWD_EN(FWD_EN), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src(ex_q.rs1), .src_used(ex_q.rs1_used),
    .mem_valid(mem_q.valid), .mem_reg_write(mem_q.reg_write), .mem_rd(mem_q.rd),
    .wb_valid(wb_q.valid), .wb_reg_write(wb_q.reg_write), .wb_rd(wb_q.rd),
    .sel(fwd_a)
  );

  fwd_sel #(.FWD_EN(FWD_EN), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src(ex_q.rs2), .src_used(ex_q.rs2_used),
    .mem_valid(mem_q.valid), .mem_reg_write(mem_q.reg_write), .mem_rd(mem_q.rd),
    .wb_valid(wb_q.valid), .wb_reg_write(wb_q.reg_write), .wb_rd(wb_q.rd),
    .sel(fwd_b)
  );

  assign ex_valid     = ex_q.valid;
  assign mem_valid    = mem_q.valid;
  assign wb_valid     = wb_q.valid;
  assign wb_rd        = wb_q.rd[REG_ADDR_W-1:0];
  assign wb_reg_write = wb_q.valid && wb_q.reg_write;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign unused_meta  = ^{mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance plus a
// no-forwarding, 2-bit-counter instance for saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_branch_taken, ext_stall;

  logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, pc_redirect;
  logic [1:0]  fwd_a, fwd_b;
  logic        ex_valid, mem_valid, wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] stall_cnt, flush_cnt;

  logic        n_pc_en, n_ifid_en, n_idex_en, n_ifid_flush, n_idex_flush, n_pc_redirect;
  logic [1:0]  n_fwd_a, n_fwd_b;
  logic        n_ex_valid, n_mem_valid, n_wb_valid, n_wb_reg_write;
  logic [4:0]  n_wb_rd;
  logic [1:0]  n_stall_cnt, n_flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pc_redirect(pc_redirect), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .CNT_W(2)) dut_nf (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .ext_stall(ext_stall),
    .pc_en(n_pc_en), .ifid_en(n_ifid_en), .idex_en(n_idex_en), .ifid_flush(n_ifid_flush),
    .idex_flush(n_idex_flush), .pc_redirect(n_pc_redirect), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
    .ex_valid(n_ex_valid), .mem_valid(n_mem_valid), .wb_valid(n_wb_valid), .wb_rd(n_wb_rd),
    .wb_reg_write(n_wb_reg_write), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic idle;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; ex_branch_taken = 1'b0; ext_stall = 1'b0;
    idle;
    #12;
    reset = 1'b0;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 1'b0);
    tick; tick; tick;
    ex_branch_taken = 1'b1;
    #1;
    tick;
    ex_branch_taken = 1'b0;
    if (flush_cnt !== 32'd1) begin bad++; $display("FAIL pre_reset_flush_cnt got=%0d exp=1", flush_cnt); end
    total++;
    if (mem_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_mem_valid got=%0b exp=1", mem_valid); end
    total++;
    if (wb_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_wb_valid got=%0b exp=1", wb_valid); end
    total++;
    #2;
    reset = 1'b1;
    #1;
    if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin bad++; $display("FAIL reset_valids got=%b exp=000", {ex_valid, mem_valid, wb_valid}); end
    total++;
    if (flush_cnt !== 32'd0 || stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", flush_cnt, stall_cnt); end
    total++;
    if ({pc_en, ifid_en, idex_en} !== 3'b000) begin bad++; $display("FAIL reset_enables got=%b exp=000", {pc_en, ifid_en, idex_en}); end
    total++;
    #1;
    reset = 1'b0;
    idle;
    #1;
    if (pc_en !== 1'b1) begin bad++; $display("FAIL release_pc_en got=%0b exp=1", pc_en); end
    total++;
  endtask

  task automatic test_fwd_alu;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    #1;
    tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin bad++; $display("FAIL alu_dep_no_stall got=%0b%0b exp=10", pc_en, idex_flush); end
    total++;
    tick;
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0);
    #1;
    if (fwd_a !== 2'b10) begin bad++; $display("FAIL alu_fwd_a_mem got=%b exp=10", fwd_a); end
    total++;
    if (fwd_b !== 2'b00) begin bad++; $display("FAIL alu_fwd_b_rf got=%b exp=00", fwd_b); end
    total++;
    tick;
    idle;
    #1;
    if (fwd_a !== 2'b01) begin bad++; $display("FAIL alu_fwd_a_wb got=%b exp=01", fwd_a); end
    total++;
    if (wb_rd !== 5'd5 || wb_reg_write !== 1'b1) begin bad++; $display("FAIL alu_wb_rd got=%0d/%0b exp=5/1", wb_rd, wb_reg_write); end
    total++;
  endtask

  task automatic test_load_use;
    idle; tick; tick; tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    #1;
    if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_flush !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0b%0b%0b exp=001", pc_en, ifid_en, idex_flush); end
    total++;
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL lu_cnt_before got=%0d exp=0", stall_cnt); end
    total++;
    tick;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got=%0b%0b exp=10", pc_en, idex_flush); end
    total++;
    if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt_after got=%0d exp=1", stall_cnt); end
    total++;
    tick;
    idle;
    #1;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin bad++; $display("FAIL lu_fwd got=%b/%b exp=01/01", fwd_a, fwd_b); end
    total++;
  endtask

  task automatic test_branch_stall;
    idle; tick; tick; tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    if ({pc_redirect, ifid_flush, idex_flush, pc_en} !== 4'b1111) begin bad++; $display("FAIL br_redirect got=%b exp=1111", {pc_redirect, ifid_flush, idex_flush, pc_en}); end
    total++;
    tick;
    ex_branch_taken = 1'b0;
    idle;
    #1;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin bad++; $display("FAIL br_counters got=%0d/%0d exp=1/1", flush_cnt, stall_cnt); end
    total++;
    if (ex_valid !== 1'b0) begin bad++; $display("FAIL br_ex_bubble got=%0b exp=0", ex_valid); end
    total++;
  endtask

  task automatic test_ext_stall;
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
    tick;
    idle;
    ex_branch_taken = 1'b1;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (pc_redirect !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("FAIL es_outputs cyc=%0d got=%0b%0b exp=00", i, pc_redirect, pc_en); end
      total++;
      tick;
      if (ex_valid !== 1'b1 || wb_valid !== 1'b1 || flush_cnt !== 32'd1) begin bad++; $display("FAIL es_hold cyc=%0d got=%0b%0b/%0d exp=11/1", i, ex_valid, wb_valid, flush_cnt); end
      total++;
    end
    ext_stall = 1'b0;
    #1;
    if (pc_redirect !== 1'b1 || pc_en !== 1'b1) begin bad++; $display("FAIL es_release got=%0b%0b exp=11", pc_redirect, pc_en); end
    total++;
    tick;
    ex_branch_taken = 1'b0;
    #1;
    if (flush_cnt !== 32'd2 || ex_valid !== 1'b0 || mem_valid !== 1'b1) begin bad++; $display("FAIL es_after got=%0d/%0b%0b exp=2/01", flush_cnt, ex_valid, mem_valid); end
    total++;
  endtask

  task automatic test_zero_reg;
    idle; tick; tick; tick;
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick;
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    #1;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0) begin bad++; $display("FAIL x0_no_stall got=%0b%0b exp=10", pc_en, idex_flush); end
    total++;
    tick;
    idle;
    #1;
    if (ex_valid !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin bad++; $display("FAIL x0_fwd got=%0b/%b/%b exp=1/00/00", ex_valid, fwd_a, fwd_b); end
    total++;
  endtask

  task automatic test_saturation;
    int exp_cnt[8] = '{0, 1, 2, 2, 3, 3, 3, 3};
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    if (n_stall_cnt !== 2'd0) begin bad++; $display("FAIL sat_start got=%0d exp=0", n_stall_cnt); end
    total++;
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick;
      if (n_stall_cnt !== 2'(exp_cnt[k])) begin bad++; $display("FAIL sat_cnt tick=%0d got=%0d exp=%0d", k + 1, n_stall_cnt, exp_cnt[k]); end
      total++;
    end
    if (stall_cnt !== 32'd0) begin bad++; $display("FAIL sat_fwd_no_stall got=%0d exp=0", stall_cnt); end
    total++;
    idle;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fwd_alu;
    test_load_use;
    test_branch_stall;
    test_ext_stall;
    test_zero_reg;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
